// File: rtl/fp_convert_ctrl.sv
// fp_convert_ctrl: 12-bit two's-complement sample -> 8-bit float code {S, E[2:0], F[3:0]}.
// Value is approximately F * 2^E. The magnitude is normalised one bit per cycle and then
// rounded half-up. The result is held on a valid/ready output until it is accepted.
module fp_convert_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        S,
  output logic [2:0]  E,
  output logic [3:0]  F,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [10:0] mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        s_q, s_d;
  logic [2:0]  e_q, e_d;
  logic [3:0]  f_q, f_d;
  logic        in_ready_q, out_valid_q, busy_q;

  logic [11:0] neg_data;
  logic [10:0] cap_mag;
  logic [3:0]  rnd_f;
  logic        rnd_r;

  // Magnitude at capture: -2048 has no 11-bit magnitude and is clamped to 2047.
  always_comb begin
    neg_data = ~in_data + 12'd1;
    if (!in_data[11])            cap_mag = in_data[10:0];
    else if (in_data == 12'h800) cap_mag = 11'h7FF;
    else                         cap_mag = neg_data[10:0];
    rnd_f = mag_q[10:7];
    rnd_r = mag_q[6];
  end

  // Next-state and datapath updates for the capture / normalise / round / hold sequence.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    s_d     = s_q;
    e_d     = e_q;
    f_d     = f_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[11];
          mag_d   = cap_mag;
          cnt_d   = 3'd7;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q[10] || cnt_q == 3'd0) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[9:0], 1'b0};
          cnt_d = cnt_q - 3'd1;
        end
      end
      ROUND: begin
        s_d = sign_q;
        if (!rnd_r) begin
          f_d = rnd_f;
          e_d = cnt_q;
        end else if (rnd_f != 4'hF) begin
          f_d = rnd_f + 4'd1;
          e_d = cnt_q;
        end else if (cnt_q != 3'd7) begin
          // A carry out of F renormalises to 1.000 with the next exponent.
          f_d = 4'd8;
          e_d = cnt_q + 3'd1;
        end else begin
          // The largest exponent cannot take the carry, so clamp to the format maximum.
          f_d = 4'hF;
          e_d = 3'd7;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and status registers. The status flags are decoded from the next state,
  // so every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= 3'd7;
      sign_q      <= 1'b0;
      s_q         <= 1'b0;
      e_q         <= '0;
      f_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      s_q         <= s_d;
      e_q         <= e_d;
      f_q         <= f_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == NORM) || (state_d == ROUND);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign S         = s_q;
  assign E         = e_q;
  assign F         = f_q;

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// Scoreboard bench for fp_convert_ctrl. It runs directed corner cases and random samples
// against an arithmetic reference model.
module tb_fp_convert_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        busy;

  fp_convert_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .E(E), .F(F), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sef;
    int         t0;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   cmp = 0;
  int   errs = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: E is the smallest exponent that brings the magnitude below 16.
  // F is the magnitude divided by 2^E and rounded half-up, with a carry to 16 renormalised.
  function automatic logic [7:0] ref_conv(input logic [11:0] d);
    int v, mag, e, f;
    v   = d[11] ? int'(d) - 4096 : int'(d);
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    e = 0;
    while ((mag >> e) >= 16) e++;
    f = (e == 0) ? mag : ((mag + (1 << (e - 1))) >> e);
    if (f == 16) begin
      if (e < 7) begin f = 8; e++; end
      else f = 15;
    end
    return {(v < 0), 3'(e), 4'(f)};
  endfunction

  // Latency from the accept edge: 2 cycles plus one per leading zero of the 11-bit magnitude,
  // with at most 7 leading zeros counted.
  function automatic int ref_lat(input logic [11:0] d);
    int v, mag, b, lz;
    v   = d[11] ? int'(d) - 4096 : int'(d);
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    b = 0;
    while ((1 << b) <= mag) b++;
    lz = 11 - b;
    return ((lz > 7) ? 7 : lz) + 2;
  endfunction

  // Hand a sample over on a valid/ready handshake and, if asked, push its expected response.
  task automatic issue(input logic [11:0] d, input bit push);
    int   n = 0;
    exp_t x;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push) begin
        x.sef = ref_conv(d);
        x.t0  = cyc;
        x.lat = ref_lat(d);
        sb.push_back(x);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin @(negedge clk); n++; end
    chk("drain_timeout", int'(sb.size() == 0 && !out_valid), 1);
  endtask

  // Monitor: when out_valid rises, compare the result and its latency against the queue head.
  // While out_valid stays high, check that S/E/F do not change.
  bit         prev_v = 1'b0;
  logic [7:0] held;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("sef", int'({S, E, F}), int'(x.sef));
          chk("latency", cyc - x.t0, x.lat);
        end
      end else if (out_valid && prev_v) begin
        chk("sef_stable", int'({S, E, F}), int'(held));
      end
      prev_v = out_valid;
      held   = {S, E, F};
    end
  end

  // Randomly stall the consumer during the random phase.
  always @(negedge clk) if (rand_rdy) out_ready = 1'($urandom % 2);

  logic [11:0] dir[] = '{12'h000, 12'h1A6, 12'd125, 12'h800, 12'd2047, 12'hFFF, 12'd1024, 12'd15};

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_S", S, 0);          chk("rst_E", E, 0);           chk("rst_F", F, 0);
    chk("rst_out_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_in_ready", in_ready, 1);
    #20;
    @(negedge clk); rst = 1'b0;

    // Directed corner values, consumer always ready.
    foreach (dir[i]) begin issue(dir[i], 1'b1); drain(); end

    // Stall in DONE for 5 cycles while in_valid is pulsed. The pulsed sample must be ignored.
    out_ready = 1'b0;
    issue(12'h1A6, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("hold_reached_done", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0);
      in_data  = 12'd5;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sef", int'({S, E, F}), int'(ref_conv(12'h1A6)));
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    repeat (12) @(negedge clk);
    chk("pulse_ignored_busy", busy, 0);
    chk("pulse_ignored_q", sb.size(), 0);

    // Reset while NORM is running for -3. The sample is dropped and the outputs clear at once.
    issue(12'hFFD, 1'b0);
    @(posedge clk); #1;
    chk("mid_norm_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);   chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_sef", int'({S, E, F}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(12'd64, 1'b1);
    drain();

    // Random samples under random consumer back-pressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [11:0] d;
      case ($urandom % 4)
        0:       d = 12'($urandom % 16);
        1:       d = 12'(4096 - ($urandom % 16));
        default: d = 12'($urandom);
      endcase
      issue(d, 1'b1);
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_convert_ctrl.md
# fp_convert_ctrl

Sequential controller that converts a 12-bit two's-complement sample into the lab's 8-bit floating-point code: a sign bit, a 3-bit exponent E and a 4-bit significand F, where value ≈ F·2^E. It accepts one sample per valid/ready handshake and derives sign and magnitude at capture. It then normalises the magnitude by iterative one-bit-per-cycle shifting, applies round-half-up, and presents the result on a held output handshake. It sits between the switch/sample input stage and the display/output stage of the converter design.

## Interface
- No parameters; all widths are fixed by the number format.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample on in_data is valid
- in_data  in  12  two's-complement sample
- in_ready  out  1  block can accept a sample (high only in IDLE)
- out_valid  out  1  S/E/F hold a finished result
- out_ready  in  1  consumer accepts the result
- S  out  1  sign
- E  out  3  exponent
- F  out  4  significand
- busy  out  1  high in NORM or ROUND

## Operation
- States: IDLE, NORM, ROUND, DONE. Reset enters IDLE.
- Reset values: S=0, E=0, F=0, out_valid=0, busy=0, in_ready=1. Internal magnitude register=0, exponent counter=7.
- IDLE behaviour:
  - in_ready=1.
  - On in_valid&in_ready, capture sign=in_data[11] and an 11-bit magnitude:
    - in_data[11]=0: magnitude=in_data[10:0].
    - in_data[11]=1: magnitude=(~in_data+1)[10:0].
    - in_data=0x800 (-2048): magnitude saturates to 2047.
  - After capture: exponent counter=7, go to NORM.
- NORM behaviour:
  - If magnitude[10]=1 or counter=0, go to ROUND.
  - Otherwise shift magnitude left by 1 with zero fill and decrement the counter. Exactly one shift per cycle.
- ROUND behaviour:
  - f=magnitude[10:7], r=magnitude[6].
  - r=0: F=f, E=counter.
  - r=1 and f<15: F=f+1, E=counter.
  - r=1, f=15, counter<7: F=8, E=counter+1.
  - r=1, f=15, counter=7: saturate to F=15, E=7.
  - S=sign. Go to DONE.
- DONE behaviour:
  - out_valid=1; S/E/F are held stable.
  - On out_ready=1, clear out_valid and go to IDLE.
  - S/E/F keep their last values until the next ROUND.
- Zero input produces S=0, E=0, F=0; the counter runs to 0.
- Negative zero cannot occur. -1 produces S=1, E=0, F=1.
- in_valid outside IDLE is ignored; there is no queuing.
- Asserting rst in any state returns to IDLE at once with the reset values. A partially processed sample is discarded.

## Timing
- Let n = number of left shifts = min(7, leading zeros of the 11-bit magnitude), range 0..7.
- Accept edge t0. NORM occupies edges t0+1..t0+n+1; ROUND is evaluated at edge t0+n+2.
- out_valid is high from edge t0+n+2.
- Latency ranges from 2 cycles (magnitude ≥1024) to 9 cycles (magnitude ≤15).
- All outputs are registered; there is no combinational path from the inputs to the outputs.
- in_ready returns to 1 in the cycle after the out_ready handshake edge.
- Back-to-back throughput is at best one sample per n+4 cycles.
- If out_ready is held high, DONE lasts exactly one cycle.

## Test plan
- Reset then in_data=0: S=0, E=0, F=0; out_valid rises 9 cycles after the accept edge.
- in_data=422 (0x1A6): n=2 → S=0, E=5, F=13; out_valid 4 cycles after accept.
- in_data=125: round carries out of F → S=0, E=4, F=8.
- in_data=0x800 (-2048) and in_data=2047: both give E=7, F=15 via saturation, with S=1 and S=0 respectively. in_data=0xFFF (-1) gives S=1, E=0, F=1.
- Hold out_ready=0 for 5 cycles in DONE while in_valid is pulsed: S/E/F stay stable, in_ready stays 0 and the pulsed sample is not taken. Raising out_ready gives in_ready=1 in the next cycle.
- Assert rst mid-NORM for in_data=-3: all outputs return to their reset values asynchronously. A new sample of 64 after release gives S=0, E=3, F=8.
